// File: rtl/btn_debounce.sv
// Four-button front end: two-flop synchroniser, per-bit debounce, one-hot press strobe with code and count.
// Define BTN_REPEAT_EN to build auto-repeat strobes while a single button stays held.
module btn_debounce #(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btns,
  output logic [3:0] btn_level,
  output logic       press_pulse,
  output logic [1:0] press_code,
  output logic       multi_err,
  output logic [7:0] press_count
);
  localparam int               CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [3:0]       sync_p0, sync_p1;
  logic [3:0]       stable_p2, stable_nxt;
  logic [CNT_W-1:0] cnt_p2  [4];
  logic [CNT_W-1:0] cnt_nxt [4];
  logic [3:0]       rise_p3;
  logic             idle_p3;
  logic             accept, multi, rpt_fire;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] encode(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btns;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-bit debounce, a bounce back to the old level restarts the count
  always_comb begin
    stable_nxt = stable_p2;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = '0;
      if (sync_p1[i] != stable_p2[i]) begin
        if (cnt_p2[i] == CNT_LAST) stable_nxt[i] = sync_p1[i];
        else                       cnt_nxt[i]    = cnt_p2[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_p2 <= '0;
      for (int i = 0; i < 4; i++) cnt_p2[i] <= '0;
    end else begin
      stable_p2 <= stable_nxt;
      for (int i = 0; i < 4; i++) cnt_p2[i] <= cnt_nxt[i];
    end
  end

  assign btn_level = stable_p2;

  // Stage p3: rising edges of the debounced levels, plus whether all buttons were up before
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_p3 <= '0;
      idle_p3 <= 1'b0;
    end else begin
      rise_p3 <= stable_nxt & ~stable_p2;
      idle_p3 <= (stable_p2 == 4'b0000);
    end
  end

  assign accept = idle_p3 && is_one_hot(rise_p3);
  assign multi  = idle_p3 && (rise_p3 != 4'b0000) && !is_one_hot(rise_p3);

`ifdef BTN_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt, rpt_limit;
  logic             rpt_active, rpt_first, stable_hold;

  assign stable_hold = (stable_nxt == stable_p2);
  assign rpt_limit   = rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
  assign rpt_fire    = rpt_active && stable_hold && (rpt_cnt == rpt_limit);

  // Repeat timer: armed by an accepted press, killed by any change of the debounced levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_active <= 1'b0;
      rpt_first  <= 1'b0;
      rpt_cnt    <= '0;
    end else if (!stable_hold) begin
      rpt_active <= 1'b0;
      rpt_first  <= 1'b0;
      rpt_cnt    <= '0;
    end else if (accept) begin
      rpt_active <= 1'b1;
      rpt_first  <= 1'b1;
      rpt_cnt    <= '0;
    end else if (rpt_active) begin
      if (rpt_cnt == rpt_limit) begin
        rpt_first <= 1'b0;
        rpt_cnt   <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end
  end
`else
  // Without auto-repeat the timing parameters are positive, so this is constant 0.
  assign rpt_fire = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

  // Stage p4: registered strobes, code and count all change on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pulse <= 1'b0;
      multi_err   <= 1'b0;
      press_code  <= 2'd0;
      press_count <= 8'd0;
    end else begin
      press_pulse <= accept || rpt_fire;
      multi_err   <= multi;
      if (accept) press_code <= encode(rise_p3);
      if (accept || rpt_fire) press_count <= press_count + 8'd1;
    end
  end
endmodule
